// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the AXI3 SRAM responder.
package axi_slave_pkg;

  localparam int unsigned ID_W    = 4;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned LAT_W   = 4;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wr_state_t;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } axi_req_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat byte address and burst legality for one AXI request.
module axi_burst_addr_gen
  import axi_slave_pkg::*;
(
  input  axi_req_t          req,
  output logic [ADDR_W-1:0] next_addr_c,
  output logic              legal_c
);

  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    inc         = ADDR_W'(1) << req.size;
    incr_addr   = req.addr + inc;
    wrap_mask   = ((ADDR_W'(req.len) + ADDR_W'(1)) << req.size) - ADDR_W'(1);
    next_addr_c = req.addr;
    legal_c     = 1'b1;
    case (req.burst)
      BURST_FIXED: next_addr_c = req.addr;
      BURST_INCR:  next_addr_c = incr_addr;
      BURST_WRAP: begin
        // Only the lower bits inside the aligned wrap window advance.
        next_addr_c = (req.addr & ~wrap_mask) | (incr_addr & wrap_mask);
        legal_c     = (req.len == LEN_W'(1)) || (req.len == LEN_W'(3)) ||
                      (req.len == LEN_W'(7)) || (req.len == LEN_W'(15));
      end
      default: legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by a word-addressed SRAM; one outstanding read and
// one outstanding write, with independent read and write FSMs.
module axi_sram_slave
  import axi_slave_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 14,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned WR_LAT    = 1
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [ID_W-1:0]    arid,
  input  logic [ADDR_W-1:0]  araddr,
  input  logic [LEN_W-1:0]   arlen,
  input  logic [SIZE_W-1:0]  arsize,
  input  logic [BURST_W-1:0] arburst,
  input  logic [1:0]         arlock,
  input  logic [3:0]         arcache,
  input  logic [2:0]         arprot,
  input  logic               arvalid,
  output logic               arready,
  output logic [ID_W-1:0]    rid,
  output logic [DATA_W-1:0]  rdata,
  output logic [RESP_W-1:0]  rresp,
  output logic               rlast,
  output logic               rvalid,
  input  logic               rready,
  input  logic [ID_W-1:0]    awid,
  input  logic [ADDR_W-1:0]  awaddr,
  input  logic [LEN_W-1:0]   awlen,
  input  logic [SIZE_W-1:0]  awsize,
  input  logic [BURST_W-1:0] awburst,
  input  logic [1:0]         awlock,
  input  logic [3:0]         awcache,
  input  logic [2:0]         awprot,
  input  logic               awvalid,
  output logic               awready,
  input  logic [ID_W-1:0]    wid,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [STRB_W-1:0]  wstrb,
  input  logic               wlast,
  input  logic               wvalid,
  output logic               wready,
  output logic [ID_W-1:0]    bid,
  output logic [RESP_W-1:0]  bresp,
  output logic               bvalid,
  input  logic               bready
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  logic [DATA_W-1:0] mem [DEPTH];

  logic unused_c;
  assign unused_c = ^{arlock, arcache, arprot, awlock, awcache, awprot};

  // ---------------- read channel ----------------
  rd_state_t         rd_state, rd_state_d;
  axi_req_t          rd_req, rd_req_d, rd_cur;
  logic [LAT_W-1:0]  rd_cnt, rd_cnt_d;
  logic [LEN_W-1:0]  rd_beat, rd_beat_d, rd_beat_n;
  logic [ADDR_W-1:0] rd_next_addr, rd_beat_addr;
  logic              rd_legal, rd_load_first, rd_load;
  logic              arready_d, rvalid_d, rlast_d;
  logic [ID_W-1:0]   rid_d;
  logic [DATA_W-1:0] rdata_d;
  logic [RESP_W-1:0] rresp_d;
  logic              ar_hs, r_hs;

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  // While idle the generator looks at the incoming request, otherwise the latched one.
  always_comb begin
    rd_cur = rd_req;
    if (rd_state == R_IDLE) begin
      rd_cur.id    = arid;
      rd_cur.addr  = araddr;
      rd_cur.len   = arlen;
      rd_cur.size  = arsize;
      rd_cur.burst = arburst;
    end
  end

  axi_burst_addr_gen u_rd_gen (.req(rd_cur), .next_addr_c(rd_next_addr), .legal_c(rd_legal));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state <= R_IDLE;
      rd_req   <= '0;
      rd_cnt   <= '0;
      rd_beat  <= '0;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rid      <= '0;
      rdata    <= '0;
      rresp    <= '0;
      rlast    <= 1'b0;
    end else begin
      rd_state <= rd_state_d;
      rd_req   <= rd_req_d;
      rd_cnt   <= rd_cnt_d;
      rd_beat  <= rd_beat_d;
      arready  <= arready_d;
      rvalid   <= rvalid_d;
      rid      <= rid_d;
      rdata    <= rdata_d;
      rresp    <= rresp_d;
      rlast    <= rlast_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_state_d = (RD_LAT == 0) ? R_BURST : R_WAIT;
      R_WAIT:  if (rd_cnt <= LAT_W'(1)) rd_state_d = R_BURST;
      R_BURST: if (r_hs && rlast) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    arready_d     = arready;
    rvalid_d      = rvalid;
    rid_d         = rid;
    rdata_d       = rdata;
    rresp_d       = rresp;
    rlast_d       = rlast;
    rd_req_d      = rd_req;
    rd_cnt_d      = rd_cnt;
    rd_beat_d     = rd_beat;
    rd_load_first = 1'b0;
    rd_load       = 1'b0;
    rd_beat_addr  = rd_cur.addr;
    rd_beat_n     = '0;
    case (rd_state)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d     = 1'b0;
          rd_req_d      = rd_cur;
          rd_cnt_d      = LAT_W'(RD_LAT);
          rd_load_first = (RD_LAT == 0);
        end
      end
      R_WAIT: begin
        rd_cnt_d      = rd_cnt - LAT_W'(1);
        rd_load_first = (rd_cnt <= LAT_W'(1));
      end
      R_BURST: begin
        if (r_hs) begin
          if (rlast) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            rd_load = 1'b1;
          end
        end
      end
      default: ;
    endcase
    // Present a beat; an illegal burst collapses to one SLVERR beat with no memory read.
    if (rd_load_first || rd_load) begin
      rd_beat_addr  = rd_load_first ? rd_cur.addr : rd_next_addr;
      rd_beat_n     = rd_load_first ? '0 : rd_beat + LEN_W'(1);
      rvalid_d      = 1'b1;
      rid_d         = rd_cur.id;
      rresp_d       = rd_legal ? RESP_OKAY : RESP_SLVERR;
      rdata_d       = rd_legal ? mem[rd_beat_addr[ADDR_BITS+1:2]] : '0;
      rlast_d       = !rd_legal || (rd_beat_n == rd_cur.len);
      rd_beat_d     = rd_beat_n;
      rd_req_d.addr = rd_beat_addr;
    end
  end

  // ---------------- write channel ----------------
  wr_state_t         wr_state, wr_state_d;
  axi_req_t          wr_req, wr_req_d, wr_cur;
  logic [LAT_W-1:0]  wr_cnt, wr_cnt_d;
  logic [LEN_W-1:0]  wr_beat, wr_beat_d;
  logic [ADDR_W-1:0] wr_next_addr;
  logic              wr_legal, wr_err, wr_err_d, wr_final, mem_we;
  logic              awready_d, wready_d, bvalid_d;
  logic [ID_W-1:0]   bid_d;
  logic [RESP_W-1:0] bresp_d;
  logic              aw_hs, w_hs, b_hs;

  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign b_hs     = bvalid && bready;
  assign wr_final = (wr_beat == wr_req.len);

  always_comb begin
    wr_cur = wr_req;
    if (wr_state == W_IDLE) begin
      wr_cur.id    = awid;
      wr_cur.addr  = awaddr;
      wr_cur.len   = awlen;
      wr_cur.size  = awsize;
      wr_cur.burst = awburst;
    end
  end

  axi_burst_addr_gen u_wr_gen (.req(wr_cur), .next_addr_c(wr_next_addr), .legal_c(wr_legal));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state <= W_IDLE;
      wr_req   <= '0;
      wr_cnt   <= '0;
      wr_beat  <= '0;
      wr_err   <= 1'b0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= '0;
    end else begin
      wr_state <= wr_state_d;
      wr_req   <= wr_req_d;
      wr_cnt   <= wr_cnt_d;
      wr_beat  <= wr_beat_d;
      wr_err   <= wr_err_d;
      awready  <= awready_d;
      wready   <= wready_d;
      bvalid   <= bvalid_d;
      bid      <= bid_d;
      bresp    <= bresp_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state;
    case (wr_state)
      W_IDLE: if (aw_hs) wr_state_d = W_DATA;
      W_DATA: if (w_hs && wr_final) wr_state_d = (WR_LAT == 0) ? W_RESP : W_WAIT;
      W_WAIT: if (wr_cnt <= LAT_W'(1)) wr_state_d = W_RESP;
      W_RESP: if (b_hs) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    awready_d = awready;
    wready_d  = wready;
    bvalid_d  = bvalid;
    bid_d     = bid;
    bresp_d   = bresp;
    wr_req_d  = wr_req;
    wr_cnt_d  = wr_cnt;
    wr_beat_d = wr_beat;
    wr_err_d  = wr_err;
    mem_we    = 1'b0;
    case (wr_state)
      W_IDLE: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wr_req_d  = wr_cur;
          wr_beat_d = '0;
          wr_err_d  = !wr_legal;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          mem_we = wr_legal;
          // The burst ends on the beat count; a wrong wid or wlast only flags the response.
          if ((wid != wr_req.id) || (wlast != wr_final)) wr_err_d = 1'b1;
          if (wr_final) begin
            wready_d = 1'b0;
            wr_cnt_d = LAT_W'(WR_LAT);
            if (WR_LAT == 0) begin
              bvalid_d = 1'b1;
              bid_d    = wr_req.id;
              bresp_d  = wr_err_d ? RESP_SLVERR : RESP_OKAY;
            end
          end else begin
            wr_req_d.addr = wr_next_addr;
            wr_beat_d     = wr_beat + LEN_W'(1);
          end
        end
      end
      W_WAIT: begin
        wr_cnt_d = wr_cnt - LAT_W'(1);
        if (wr_cnt <= LAT_W'(1)) begin
          bvalid_d = 1'b1;
          bid_d    = wr_req.id;
          bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Byte-strobed SRAM write; contents are deliberately not reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb[b]) mem[wr_req.addr[ADDR_BITS+1:2]][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave (RD_LAT = WR_LAT = 1).
module tb_axi_sram_slave;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd2;
  logic [1:0]  arburst = 2'b01;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;
  logic        rready = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'd2;
  logic [1:0]  awburst = 2'b01;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_data [16];
  logic [3:0]  cap_id   [16];
  logic [1:0]  cap_resp [16];
  logic        cap_last [16];
  int          cap_n, cap_lat, hold_viol;
  logic [3:0]  wb_bid;
  logic [1:0]  wb_bresp;
  int          wb_viol;

  wire [49:0] all_outs = {arready, rvalid, rid, rdata, rresp, rlast,
                          awready, wready, bvalid, bid, bresp};

  axi_sram_slave #(.ADDR_BITS(14), .RD_LAT(1), .WR_LAT(1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'b00), .arcache(4'h0), .arprot(3'b000),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(2'b00), .awcache(4'h0), .awprot(3'b000),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Issue one read burst and capture every accepted beat.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit toggle);
    int cyc, k, t;
    bit done, have_hold;
    logic [31:0] held;
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    rready = 1'b0;
    for (t = 0; t < 50 && !arready; t++) tick();
    if (!arready) begin
      checks++; errors++;
      $display("FAIL ar_timeout: arready got %b required 1", arready);
    end
    tick();
    arvalid = 1'b0;
    cyc = 1; k = 0; done = 0; have_hold = 0; held = '0;
    cap_n = 0; cap_lat = -1; hold_viol = 0;
    for (t = 0; t < 100 && !done; t++) begin
      if (rvalid) begin
        if (cap_lat < 0) cap_lat = cyc;
        if (have_hold && rdata !== held) hold_viol++;
        rready = toggle ? (k % 2 == 0) : 1'b1;
        k++;
        if (rready) begin
          if (cap_n < 16) begin
            cap_data[cap_n] = rdata; cap_id[cap_n] = rid;
            cap_resp[cap_n] = rresp; cap_last[cap_n] = rlast;
          end
          cap_n++;
          have_hold = 0;
          if (rlast) done = 1;
        end else begin
          held = rdata;
          have_hold = 1;
        end
      end else begin
        rready = 1'b0;
        if (have_hold) hold_viol++;
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL r_timeout: beats got %0d, no rlast accepted", cap_n);
    end
  endtask

  // Issue one write burst; data per beat is data0 + beat, wlast on beat last_beat.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [31:0] data0, input logic [3:0] strb,
                          input int last_beat, input int bready_delay);
    int t;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    for (t = 0; t < 50 && !awready; t++) tick();
    if (!awready) begin
      checks++; errors++;
      $display("FAIL aw_timeout: awready got %b required 1", awready);
    end
    tick();
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wid = id; wdata = data0 + 32'(b); wstrb = strb; wlast = (b == last_beat); wvalid = 1'b1;
      for (t = 0; t < 50 && !wready; t++) tick();
      if (!wready) begin
        checks++; errors++;
        $display("FAIL w_timeout: wready got %b required 1", wready);
      end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    for (t = 0; t < 50 && !bvalid; t++) tick();
    if (!bvalid) begin
      checks++; errors++;
      $display("FAIL b_timeout: bvalid got %b required 1", bvalid);
    end
    wb_bid = bid; wb_bresp = bresp; wb_viol = 0;
    repeat (bready_delay) begin
      tick();
      if (!bvalid) wb_viol++;
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    repeat (3) begin
      if (bvalid) wb_viol++;
      tick();
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    checks++;
    if (all_outs !== 50'h0) begin
      errors++; $display("FAIL reset_outs: got %h required 0", all_outs);
    end
    #2 aresetn = 1'b1;
    checks++;
    if ({arready, awready} !== 2'b00) begin
      errors++; $display("FAIL ready_before_edge: got %b required 00", {arready, awready});
    end
    tick();
    checks++;
    if ({arready, awready, wready} !== 3'b110) begin
      errors++; $display("FAIL ready_after_release: got %b required 110", {arready, awready, wready});
    end
  endtask

  task automatic test_incr_refill();
    do_write(4'd9, 32'h400, 8'd15, 2'b01, 32'h0, 4'hF, 15, 0);
    checks++;
    if ({wb_bid, wb_bresp} !== {4'd9, 2'b00}) begin
      errors++; $display("FAIL preload_resp: got %h required %h", {wb_bid, wb_bresp}, {4'd9, 2'b00});
    end
    do_read(4'd5, 32'h400, 8'd3, 2'b01, 1'b0);
    checks++;
    if (cap_lat !== 2) begin
      errors++; $display("FAIL incr_latency: got %0d required 2", cap_lat);
    end
    checks++;
    if (cap_n !== 4) begin
      errors++; $display("FAIL incr_beats: got %0d required 4", cap_n);
    end
    for (int i = 0; i < 4; i++) begin
      logic [38:0] got, exp;
      got = {cap_id[i], cap_data[i], cap_resp[i], cap_last[i]};
      exp = {4'd5, 32'(i), 2'b00, (i == 3)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL incr_beat%0d id_data_resp_last: got %h required %h", i, got, exp);
      end
    end
  endtask

  task automatic test_wrap_read();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h2; exp_w[1] = 32'h3; exp_w[2] = 32'h0; exp_w[3] = 32'h1;
    do_read(4'd2, 32'h408, 8'd3, 2'b10, 1'b1);
    checks++;
    if (cap_n !== 4) begin
      errors++; $display("FAIL wrap_beats: got %0d required 4", cap_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({cap_data[i], cap_resp[i], cap_last[i]} !== {exp_w[i], 2'b00, (i == 3)}) begin
        errors++;
        $display("FAIL wrap_beat%0d: got %h required %h", i,
                 {cap_data[i], cap_resp[i], cap_last[i]}, {exp_w[i], 2'b00, (i == 3)});
      end
    end
    checks++;
    if (hold_viol !== 0) begin
      errors++; $display("FAIL wrap_hold: got %0d payload changes while stalled, required 0", hold_viol);
    end
    do_read(4'd1, 32'h404, 8'd2, 2'b00, 1'b0);
    checks++;
    if ({cap_n, cap_data[0], cap_data[1], cap_data[2]} !== {32'd3, 32'h1, 32'h1, 32'h1}) begin
      errors++;
      $display("FAIL fixed_read: got n=%0d %h %h %h required n=3 1 1 1",
               cap_n, cap_data[0], cap_data[1], cap_data[2]);
    end
  endtask

  task automatic test_strobed_write();
    do_write(4'd1, 32'h800, 8'd0, 2'b01, 32'h11223344, 4'hF, 0, 0);
    do_write(4'd3, 32'h800, 8'd0, 2'b01, 32'hAABBCCDD, 4'b0101, 0, 0);
    checks++;
    if ({wb_bid, wb_bresp} !== {4'd3, 2'b00}) begin
      errors++; $display("FAIL strobe_resp: got %h required %h", {wb_bid, wb_bresp}, {4'd3, 2'b00});
    end
    do_read(4'd0, 32'h800, 8'd0, 2'b01, 1'b0);
    checks++;
    if (cap_data[0] !== 32'h11BB33DD) begin
      errors++; $display("FAIL strobe_0101: got %h required 11bb33dd", cap_data[0]);
    end
    do_write(4'd3, 32'h800, 8'd0, 2'b01, 32'hEE000000, 4'b1000, 0, 0);
    do_read(4'd0, 32'h800, 8'd0, 2'b01, 1'b0);
    checks++;
    if (cap_data[0] !== 32'hEEBB33DD) begin
      errors++; $display("FAIL strobe_1000: got %h required eebb33dd", cap_data[0]);
    end
  endtask

  task automatic test_errors();
    do_read(4'd6, 32'h400, 8'd3, 2'b11, 1'b0);
    checks++;
    if ({cap_n, cap_id[0], cap_resp[0], cap_last[0]} !== {32'd1, 4'd6, 2'b10, 1'b1}) begin
      errors++;
      $display("FAIL rd_reserved: got n=%0d id=%h resp=%b last=%b required n=1 id=6 resp=10 last=1",
               cap_n, cap_id[0], cap_resp[0], cap_last[0]);
    end
    do_read(4'd6, 32'h400, 8'd2, 2'b10, 1'b0);
    checks++;
    if ({cap_n, cap_resp[0]} !== {32'd1, 2'b10}) begin
      errors++; $display("FAIL rd_wrap_len2: got n=%0d resp=%b required n=1 resp=10", cap_n, cap_resp[0]);
    end
    do_write(4'd2, 32'h404, 8'd0, 2'b11, 32'hDEADBEEF, 4'hF, 0, 0);
    checks++;
    if (wb_bresp !== 2'b10) begin
      errors++; $display("FAIL wr_reserved_resp: got %b required 10", wb_bresp);
    end
    do_read(4'd0, 32'h404, 8'd0, 2'b01, 1'b0);
    checks++;
    if (cap_data[0] !== 32'h1) begin
      errors++; $display("FAIL wr_reserved_untouched: got %h required 00000001", cap_data[0]);
    end
    do_write(4'd4, 32'h840, 8'd1, 2'b01, 32'hC0DE0000, 4'hF, 0, 0);
    checks++;
    if ({wb_bid, wb_bresp} !== {4'd4, 2'b10}) begin
      errors++; $display("FAIL early_wlast_resp: got %h required %h", {wb_bid, wb_bresp}, {4'd4, 2'b10});
    end
    do_read(4'd0, 32'h840, 8'd1, 2'b01, 1'b0);
    checks++;
    if ({cap_data[0], cap_data[1]} !== {32'hC0DE0000, 32'hC0DE0001}) begin
      errors++;
      $display("FAIL early_wlast_data: got %h %h required c0de0000 c0de0001", cap_data[0], cap_data[1]);
    end
  endtask

  task automatic test_concurrency();
    do_write(4'd1, 32'h500, 8'd0, 2'b01, 32'h0A0A0A0A, 4'hF, 0, 0);
    fork
      do_read(4'd7, 32'h500, 8'd0, 2'b01, 1'b0);
      do_write(4'd4, 32'h500, 8'd0, 2'b01, 32'hB0B0B0B0, 4'hF, 0, 5);
    join
    checks++;
    if (cap_data[0] !== 32'h0A0A0A0A) begin
      errors++; $display("FAIL same_word_old: got %h required 0a0a0a0a", cap_data[0]);
    end
    checks++;
    if ({wb_bid, wb_bresp} !== {4'd4, 2'b00}) begin
      errors++; $display("FAIL conc_bresp: got %h required %h", {wb_bid, wb_bresp}, {4'd4, 2'b00});
    end
    checks++;
    if (wb_viol !== 0) begin
      errors++; $display("FAIL bvalid_hold_once: got %0d bvalid violations required 0", wb_viol);
    end
    do_read(4'd7, 32'h500, 8'd0, 2'b01, 1'b0);
    checks++;
    if (cap_data[0] !== 32'hB0B0B0B0) begin
      errors++; $display("FAIL same_word_new: got %h required b0b0b0b0", cap_data[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int stray;
    arid = 4'd1; araddr = 32'h400; arlen = 8'd15; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    for (int t = 0; t < 50 && !arready; t++) tick();
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    for (int t = 0; t < 20 && !rvalid; t++) tick();
    checks++;
    if (rvalid !== 1'b1) begin
      errors++; $display("FAIL midburst_start: rvalid got %b required 1", rvalid);
    end
    tick();
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (all_outs !== 50'h0) begin
      errors++; $display("FAIL midburst_async_clear: got %h required 0", all_outs);
    end
    rready = 1'b0;
    tick(); tick();
    checks++;
    if (all_outs !== 50'h0) begin
      errors++; $display("FAIL midburst_held_clear: got %h required 0", all_outs);
    end
    aresetn = 1'b1;
    tick();
    checks++;
    if ({arready, awready} !== 2'b11) begin
      errors++; $display("FAIL midburst_ready: got %b required 11", {arready, awready});
    end
    stray = 0;
    repeat (6) begin
      if (rvalid) stray++;
      tick();
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL midburst_stray_rvalid: got %0d required 0", stray);
    end
    do_read(4'd3, 32'h408, 8'd0, 2'b01, 1'b0);
    checks++;
    if ({cap_id[0], cap_data[0]} !== {4'd3, 32'h2}) begin
      errors++; $display("FAIL post_reset_read: got %h required %h", {cap_id[0], cap_data[0]}, {4'd3, 32'h2});
    end
  endtask

  initial begin
    test_reset();
    test_incr_refill();
    test_wrap_read();
    test_strobed_write();
    test_errors();
    test_concurrency();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
